// File: rtl/dcache_pkg.sv
// Shared definitions for the N-way L1 data cache: store-size codes, FSM
// state encoding, address field-width helpers and the store byte-lane mask.
package dcache_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRBACK = 2'd1,
      ST_FILL   = 2'd2
   } state_t;

   function automatic int calc_off_w(input int line_bits);
      return $clog2(line_bits / 8);
   endfunction

   function automatic int calc_idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int calc_tag_w(input int addr_w, input int sets, input int line_bits);
      return addr_w - calc_idx_w(sets) - calc_off_w(line_bits);
   endfunction

   // Width of a way selector; a direct-mapped cache still gets one bit.
   function automatic int calc_sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Big-endian lanes: mask bit 3 is byte offset 0 (word bits [31:24]).
   // A misaligned half is promoted to a full word access.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lsb);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b1000 >> lsb;
         SZ_HALF: m = lsb[0] ? 4'b1111 : (lsb[1] ? 4'b0011 : 4'b1100);
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU age logic for one set. Ages form a permutation of 0..WAYS-1,
// 0 being most recent. Produces the updated ages for a touched way and the
// replacement victim (lowest-index invalid way, else the oldest way).
module dcache_lru
   import dcache_pkg::*;
#(
   parameter int WAYS = 2,
   localparam int WAY_W = calc_sel_w(WAYS)
)(
   input  logic [WAYS-1:0][WAY_W-1:0] age_in,
   input  logic [WAYS-1:0]            valid_in,
   input  logic [WAY_W-1:0]           touch_way,
   output logic [WAYS-1:0][WAY_W-1:0] age_out,
   output logic [WAY_W-1:0]           victim
);

   generate
      if (WAYS == 1) begin : g_single
         // Direct-mapped: only one candidate, no ages to track
         always_comb begin
            age_out = '0;
            victim  = '0;
         end
      end else begin : g_multi
         // Touched way becomes youngest; ways younger than it age by one
         always_comb begin
            logic [WAY_W-1:0] old_age;
            old_age = age_in[touch_way];
            for (int w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == touch_way)
                  age_out[w] = '0;
               else if (age_in[w] < old_age)
                  age_out[w] = age_in[w] + 1'b1;
               else
                  age_out[w] = age_in[w];
            end
         end

         // Prefer filling an empty way before evicting the oldest one
         always_comb begin
            logic found;
            victim = '0;
            found  = 1'b0;
            for (int w = 0; w < WAYS; w++) begin
               if (!found && !valid_in[w]) begin
                  victim = WAY_W'(w);
                  found  = 1'b1;
               end
            end
            if (!found) begin
               for (int w = 0; w < WAYS; w++) begin
                  if (age_in[w] == WAY_W'(WAYS - 1))
                     victim = WAY_W'(w);
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/dcache_l1_nway.sv
// N-way set-associative, write-back, write-allocate L1 data cache with
// true-LRU replacement, byte/half stores and a line-level memory handshake.
// Optional hit/miss/write-back counters: define DCACHE_L1_STATS_EN.
module dcache_l1_nway
   import dcache_pkg::*;
#(
   parameter int WAYS      = 2,
   parameter int SETS      = 512,
   parameter int LINE_BITS = 256,
   parameter int ADDR_W    = 32
)(
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [ADDR_W-1:0]    data_address_2C,
   input  logic [31:0]          data_write_2C,
   input  logic [1:0]           data_write_size_2C,
   input  logic                 cache_read,
   input  logic                 cache_write,
   output logic [31:0]          data_read_fC,
   output logic                 miss,
   output logic                 mem_write_req,
   output logic [ADDR_W-1:0]    mem_write_addr,
   output logic [LINE_BITS-1:0] mem_write_data,
   input  logic                 mem_write_valid,
   output logic                 mem_read_req,
   output logic [ADDR_W-1:0]    mem_read_addr,
   input  logic [LINE_BITS-1:0] mem_read_data,
   input  logic                 mem_read_valid
`ifdef DCACHE_L1_STATS_EN
   ,
   output logic [31:0]          stat_hits,
   output logic [31:0]          stat_misses,
   output logic [31:0]          stat_wbacks
`endif
);

   localparam int OFF_W  = calc_off_w(LINE_BITS);
   localparam int IDX_W  = calc_idx_w(SETS);
   localparam int TAG_W  = calc_tag_w(ADDR_W, SETS, LINE_BITS);
   localparam int WAY_W  = calc_sel_w(WAYS);
   localparam int WORDS  = LINE_BITS / 32;
   localparam int WORD_W = OFF_W - 2;

   logic [TAG_W-1:0]              tag_mem   [WAYS][SETS];
   logic [LINE_BITS-1:0]          data_mem  [WAYS][SETS];
   logic [WAYS-1:0]               valid_mem [SETS];
   logic [WAYS-1:0]               dirty_mem [SETS];
   logic [WAYS-1:0][WAY_W-1:0]    age_mem   [SETS];

   state_t state, state_nxt;
   logic [ADDR_W-1:0] lat_addr;
   logic [WAY_W-1:0]  lat_way;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [WORD_W-1:0] req_word;
   logic [IDX_W-1:0]  lat_idx;
   logic              req, hit, hit_any, fill_done, miss_start, victim_dirty;
   logic [WAY_W-1:0]  hit_way, victim, lru_touch;
   logic [IDX_W-1:0]  lru_idx;
   logic [WAYS-1:0][WAY_W-1:0] lru_age_next;

   logic [WORDS-1:0][31:0] hit_words, new_words;
   logic [31:0]            wr_bus, merged_word;
   logic [3:0]             lane_en;

   assign req_tag   = data_address_2C[ADDR_W-1 -: TAG_W];
   assign req_idx   = data_address_2C[OFF_W +: IDX_W];
   assign req_word  = data_address_2C[2 +: WORD_W];
   assign lat_idx   = lat_addr[OFF_W +: IDX_W];

   assign req        = cache_read | cache_write;
   assign hit        = req & (state == ST_IDLE) & hit_any;
   assign miss       = (req & ~hit) | (state != ST_IDLE);
   assign miss_start = (state == ST_IDLE) & req & ~hit_any;
   assign fill_done  = (state == ST_FILL) & mem_read_valid;

   assign victim_dirty  = valid_mem[req_idx][victim] & dirty_mem[req_idx][victim];
   assign mem_read_addr = lat_addr;

   // Tag compare across all ways of the addressed set
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit_any && valid_mem[req_idx][w] && tag_mem[w][req_idx] == req_tag) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Word 0 sits in the top bits, so packed word index is the inverted offset
   always_comb begin
      hit_words    = data_mem[hit_way][req_idx];
      data_read_fC = hit ? hit_words[~req_word] : 32'd0;
   end

   // Replicate store data onto its lanes and merge it into the hit word
   always_comb begin
      lane_en = lane_mask(data_write_size_2C, data_address_2C[1:0]);
      case (data_write_size_2C)
         SZ_BYTE: wr_bus = {4{data_write_2C[7:0]}};
         SZ_HALF: wr_bus = data_address_2C[0] ? data_write_2C : {2{data_write_2C[15:0]}};
         default: wr_bus = data_write_2C;
      endcase
      merged_word = hit_words[~req_word];
      for (int b = 0; b < 4; b++) begin
         if (lane_en[b])
            merged_word[8*b +: 8] = wr_bus[8*b +: 8];
      end
      new_words              = hit_words;
      new_words[~req_word]   = merged_word;
   end

   // During a fill the LRU works on the latched set/way, otherwise on the hit
   always_comb begin
      lru_idx   = (state == ST_FILL) ? lat_idx : req_idx;
      lru_touch = (state == ST_FILL) ? lat_way : hit_way;
   end

   dcache_lru #(.WAYS(WAYS)) u_lru (
      .age_in    (age_mem[lru_idx]),
      .valid_in  (valid_mem[lru_idx]),
      .touch_way (lru_touch),
      .age_out   (lru_age_next),
      .victim    (victim)
   );

   // Tag and data arrays: line install on fill, word merge on store hit
   always_ff @(posedge CLK) begin
      if (fill_done) begin
         data_mem[lat_way][lat_idx] <= mem_read_data;
         tag_mem[lat_way][lat_idx]  <= lat_addr[ADDR_W-1 -: TAG_W];
      end else if (hit && cache_write) begin
         data_mem[hit_way][req_idx] <= new_words;
      end
   end

   // Valid, dirty and age state, re-initialised by reset
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int s = 0; s < SETS; s++) begin
            valid_mem[s] <= '0;
            dirty_mem[s] <= '0;
            for (int w = 0; w < WAYS; w++)
               age_mem[s][w] <= WAY_W'(w);
         end
      end else if (fill_done) begin
         valid_mem[lat_idx][lat_way] <= 1'b1;
         dirty_mem[lat_idx][lat_way] <= 1'b0;
         age_mem[lat_idx]            <= lru_age_next;
      end else if (hit) begin
         if (cache_write)
            dirty_mem[req_idx][hit_way] <= 1'b1;
         age_mem[req_idx] <= lru_age_next;
      end
   end

   // Capture the miss context; victim line is staged only when it needs writing back
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         lat_addr       <= '0;
         lat_way        <= '0;
         mem_write_addr <= '0;
         mem_write_data <= '0;
      end else if (miss_start) begin
         lat_addr <= {data_address_2C[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
         lat_way  <= victim;
         if (victim_dirty) begin
            mem_write_addr <= {tag_mem[victim][req_idx], req_idx, {OFF_W{1'b0}}};
            mem_write_data <= data_mem[victim][req_idx];
         end
      end
   end

   // Miss FSM state register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Miss FSM next state and memory request strobes
   always_comb begin
      state_nxt     = state;
      mem_write_req = 1'b0;
      mem_read_req  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (miss_start)
               state_nxt = victim_dirty ? ST_WRBACK : ST_FILL;
         end
         ST_WRBACK: begin
            mem_write_req = 1'b1;
            if (mem_write_valid)
               state_nxt = ST_FILL;
         end
         ST_FILL: begin
            mem_read_req = 1'b1;
            if (mem_read_valid)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef DCACHE_L1_STATS_EN
   // Saturating event counters
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stat_hits   <= '0;
         stat_misses <= '0;
         stat_wbacks <= '0;
      end else begin
         if (hit && stat_hits != 32'hFFFF_FFFF)
            stat_hits <= stat_hits + 32'd1;
         if (miss_start && stat_misses != 32'hFFFF_FFFF)
            stat_misses <= stat_misses + 32'd1;
         if (miss_start && victim_dirty && stat_wbacks != 32'hFFFF_FFFF)
            stat_wbacks <= stat_wbacks + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_l1_nway.sv
// Testbench for dcache_l1_nway (default 2-way, 512 sets, 256-bit lines).
// Reference model: a list of resident lines with recency stamps plus a
// byte-addressed big-endian merge and a sparse backing memory.
module tb_dcache_l1_nway;

   localparam int WAYS = 2;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [31:0]  data_address_2C;
   logic [31:0]  data_write_2C;
   logic [1:0]   data_write_size_2C;
   logic         cache_read, cache_write;
   logic [31:0]  data_read_fC;
   logic         miss;
   logic         mem_write_req;
   logic [31:0]  mem_write_addr;
   logic [255:0] mem_write_data;
   logic         mem_write_valid;
   logic         mem_read_req;
   logic [31:0]  mem_read_addr;
   logic [255:0] mem_read_data;
   logic         mem_read_valid;
`ifdef DCACHE_L1_STATS_EN
   logic [31:0]  stat_hits, stat_misses, stat_wbacks;
`endif

   dcache_l1_nway #(.WAYS(WAYS), .SETS(512), .LINE_BITS(256), .ADDR_W(32)) dut (
      .CLK                (CLK),
      .RESET              (RESET),
      .data_address_2C    (data_address_2C),
      .data_write_2C      (data_write_2C),
      .data_write_size_2C (data_write_size_2C),
      .cache_read         (cache_read),
      .cache_write        (cache_write),
      .data_read_fC       (data_read_fC),
      .miss               (miss),
      .mem_write_req      (mem_write_req),
      .mem_write_addr     (mem_write_addr),
      .mem_write_data     (mem_write_data),
      .mem_write_valid    (mem_write_valid),
      .mem_read_req       (mem_read_req),
      .mem_read_addr      (mem_read_addr),
      .mem_read_data      (mem_read_data),
      .mem_read_valid     (mem_read_valid)
`ifdef DCACHE_L1_STATS_EN
      ,
      .stat_hits          (stat_hits),
      .stat_misses        (stat_misses),
      .stat_wbacks        (stat_wbacks)
`endif
   );

   always #5 CLK = ~CLK;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0]  laddr;
      logic [255:0] data;
      bit           dirty;
      int           stamp;
   } entry_t;

   entry_t       cache_q[$];
   logic [255:0] mem_lines [logic [31:0]];
   int           stamp_ctr = 0;

   function automatic logic [8:0] set_of(input logic [31:0] a);
      return a[13:5];
   endfunction

   // Backing memory: written-back data if any, else a pattern derived from the address
   function automatic logic [255:0] backing(input logic [31:0] la);
      logic [255:0] l;
      if (mem_lines.exists(la)) return mem_lines[la];
      for (int k = 0; k < 8; k++)
         l[255 - 32*k -: 32] = (la * 32'd3) ^ (32'h0101_0101 * (k + 1)) ^ 32'h5A5A_0000;
      return l;
   endfunction

   function automatic int find_line(input logic [31:0] la);
      for (int i = 0; i < cache_q.size(); i++)
         if (cache_q[i].laddr == la) return i;
      return -1;
   endfunction

   function automatic logic [31:0] line_word(input logic [255:0] l, input int off);
      return l[255 - 32*(off/4) -: 32];
   endfunction

   // Big-endian store: byte offset n lives at line bits [255-8n -: 8]
   function automatic logic [255:0] merge_store(input logic [255:0] l, input int off,
                                                input logic [1:0] sz, input logic [31:0] wd);
      logic [255:0] r;
      int base;
      r = l;
      if (sz == 2'd0) begin
         r[255 - 8*off -: 8] = wd[7:0];
      end else if (sz == 2'd1 && (off % 2) == 0) begin
         r[255 - 8*off -: 8]       = wd[15:8];
         r[255 - 8*(off + 1) -: 8] = wd[7:0];
      end else begin
         base = off & ~3;
         for (int k = 0; k < 4; k++)
            r[255 - 8*(base + k) -: 8] = wd[31 - 8*k -: 8];
      end
      return r;
   endfunction

   // Play the memory side of one miss: optional write-back, then the fill
   task automatic service(input logic [31:0] fill_la, input bit exp_wb,
                          input logic [31:0] exp_wa, input logic [255:0] exp_wd,
                          output logic [31:0] got_wa);
      bit seen, wb_seen;
      int cyc, lat;
      got_wa = '0;
      if (exp_wb) begin
         seen = 0; cyc = 0;
         for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge CLK);
            seen = mem_write_req;
            cyc  = c;
         end
         n_cmp++;
         if (!seen) begin
            n_fail++;
            $display("[TB] FAIL wb_timeout la=%h got=no_req exp=req", exp_wa);
         end else begin
            got_wa = mem_write_addr;
            n_cmp++;
            if (cyc != 0) begin
               n_fail++;
               $display("[TB] FAIL wb_latency got=%0d exp=0", cyc);
            end
            n_cmp++;
            if (mem_write_addr !== exp_wa) begin
               n_fail++;
               $display("[TB] FAIL wb_addr got=%h exp=%h", mem_write_addr, exp_wa);
            end
            n_cmp++;
            if (mem_write_data !== exp_wd) begin
               n_fail++;
               $display("[TB] FAIL wb_data got=%h exp=%h", mem_write_data, exp_wd);
            end
            lat = $urandom_range(0, 3);
            repeat (lat) @(negedge CLK);
            mem_write_valid = 1'b1;
            @(posedge CLK); #1;
            mem_write_valid = 1'b0;
         end
      end
      seen = 0; wb_seen = 0; cyc = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge CLK);
         if (mem_write_req) wb_seen = 1;
         seen = mem_read_req;
         cyc  = c;
      end
      n_cmp++;
      if (wb_seen) begin
         n_fail++;
         $display("[TB] FAIL unexpected_wb fill=%h got=wb exp=no_wb", fill_la);
      end
      n_cmp++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL fill_timeout la=%h got=no_req exp=req", fill_la);
      end else begin
         n_cmp++;
         if (cyc != 0) begin
            n_fail++;
            $display("[TB] FAIL fill_latency got=%0d exp=0", cyc);
         end
         n_cmp++;
         if (mem_read_addr !== fill_la) begin
            n_fail++;
            $display("[TB] FAIL fill_addr got=%h exp=%h", mem_read_addr, fill_la);
         end
         lat = $urandom_range(0, 3);
         repeat (lat) @(negedge CLK);
         mem_read_data  = backing(fill_la);
         mem_read_valid = 1'b1;
         @(posedge CLK); #1;
         mem_read_valid = 1'b0;
      end
      @(negedge CLK);
   endtask

   // One load or store, held until it completes; called at posedge+1
   task automatic access(input bit wr, input logic [31:0] addr, input logic [1:0] sz,
                         input logic [31:0] wd, output logic [31:0] rd, output logic [31:0] wb_addr);
      int idx, vic, cnt, off;
      bit exp_wb;
      logic [31:0] la, vla;
      logic [255:0] vdata;
      la  = addr & ~32'h1F;
      off = int'(addr[4:0]);
      rd = '0; wb_addr = '0;
      data_address_2C    = addr;
      data_write_2C      = wd;
      data_write_size_2C = sz;
      cache_read         = !wr;
      cache_write        = wr;
      @(negedge CLK);
      idx = find_line(la);
      n_cmp++;
      if (miss !== (idx < 0)) begin
         n_fail++;
         $display("[TB] FAIL miss_flag addr=%h got=%b exp=%b", addr, miss, (idx < 0));
      end
      if (idx < 0) begin
         n_cmp++;
         if (data_read_fC !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL read_on_miss addr=%h got=%h exp=0", addr, data_read_fC);
         end
         vic = -1; cnt = 0;
         for (int i = 0; i < cache_q.size(); i++) begin
            if (set_of(cache_q[i].laddr) == set_of(la)) begin
               cnt++;
               if (vic < 0 || cache_q[i].stamp < cache_q[vic].stamp) vic = i;
            end
         end
         exp_wb = 0; vla = '0; vdata = '0;
         if (cnt == WAYS) begin
            exp_wb = cache_q[vic].dirty;
            vla    = cache_q[vic].laddr;
            vdata  = cache_q[vic].data;
         end
         service(la, exp_wb, vla, vdata, wb_addr);
         if (cnt == WAYS) begin
            if (exp_wb) mem_lines[vla] = vdata;
            cache_q.delete(vic);
         end
         cache_q.push_back('{la, backing(la), 1'b0, 0});
         idx = cache_q.size() - 1;
         n_cmp++;
         if (miss !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL hit_after_fill addr=%h got=%b exp=0", addr, miss);
         end
      end
      if (!wr) begin
         rd = data_read_fC;
         n_cmp++;
         if (data_read_fC !== line_word(cache_q[idx].data, off)) begin
            n_fail++;
            $display("[TB] FAIL read_data addr=%h got=%h exp=%h", addr, data_read_fC,
                     line_word(cache_q[idx].data, off));
         end
      end else begin
         cache_q[idx].data  = merge_store(cache_q[idx].data, off, sz, wd);
         cache_q[idx].dirty = 1'b1;
      end
      stamp_ctr++;
      cache_q[idx].stamp = stamp_ctr;
      @(posedge CLK); #1;
      cache_read  = 1'b0;
      cache_write = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      n_cmp++; if (miss !== 1'b0)            begin n_fail++; $display("[TB] FAIL rst_miss got=%b exp=0", miss); end
      n_cmp++; if (mem_write_req !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_wreq got=%b exp=0", mem_write_req); end
      n_cmp++; if (mem_read_req !== 1'b0)    begin n_fail++; $display("[TB] FAIL rst_rreq got=%b exp=0", mem_read_req); end
      n_cmp++; if (mem_write_addr !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_waddr got=%h exp=0", mem_write_addr); end
      n_cmp++; if (mem_write_data !== '0)    begin n_fail++; $display("[TB] FAIL rst_wdata got=%h exp=0", mem_write_data); end
      n_cmp++; if (data_read_fC !== 32'd0)   begin n_fail++; $display("[TB] FAIL rst_rdata got=%h exp=0", data_read_fC); end
      RESET = 1'b0;
      cache_q.delete();
      @(posedge CLK); #1;
   endtask

   task automatic test_cold_read();
      logic [31:0] rd, wa;
      mem_lines[32'h0000_1000] = {32'h0123_4567, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_F00D,
                                  32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
      access(1'b0, 32'h0000_1004, 2'd2, 32'd0, rd, wa);
      n_cmp++;
      if (rd !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("[TB] FAIL cold_read got=%h exp=DEADBEEF", rd);
      end
   endtask

   task automatic test_byte_store();
      logic [31:0] rd, wa;
      access(1'b1, 32'h0000_1005, 2'd0, 32'h0000_00AA, rd, wa);
      access(1'b0, 32'h0000_1004, 2'd2, 32'd0, rd, wa);
      n_cmp++;
      if (rd !== 32'hDEAA_BEEF) begin
         n_fail++;
         $display("[TB] FAIL byte_store got=%h exp=DEAABEEF", rd);
      end
   endtask

   task automatic test_evict_dirty();
      logic [31:0] rd, wa;
      access(1'b0, 32'h0000_5000, 2'd2, 32'd0, rd, wa);
      access(1'b0, 32'h0000_9000, 2'd2, 32'd0, rd, wa);
      n_cmp++;
      if (wa !== 32'h0000_1000) begin
         n_fail++;
         $display("[TB] FAIL evict_addr got=%h exp=00001000", wa);
      end
   endtask

   task automatic test_lru_victim();
      logic [31:0] rd, wa;
      access(1'b0, 32'h0000_5008, 2'd2, 32'd0, rd, wa);
      access(1'b0, 32'h0000_D000, 2'd2, 32'd0, rd, wa);
      access(1'b0, 32'h0000_5000, 2'd2, 32'd0, rd, wa);
      access(1'b0, 32'h0000_9000, 2'd2, 32'd0, rd, wa);
   endtask

   task automatic test_reset_in_fill();
      bit seen;
      logic [31:0] rd, wa;
      data_address_2C = 32'h0000_2000;
      cache_read      = 1'b1;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge CLK);
         seen = mem_read_req;
      end
      n_cmp++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL rf_fill_timeout got=no_req exp=req");
      end
      RESET = 1'b1;
      #1;
      n_cmp++;
      if (mem_read_req !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rf_rreq got=%b exp=0", mem_read_req);
      end
      mem_read_data  = '1;
      mem_read_valid = 1'b1;
      @(posedge CLK); #1;
      mem_read_valid = 1'b0;
      cache_read     = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      cache_q.delete();
      @(posedge CLK); #1;
      access(1'b0, 32'h0000_5000, 2'd2, 32'd0, rd, wa);
      access(1'b0, 32'h0000_2000, 2'd2, 32'd0, rd, wa);
   endtask

   task automatic test_stray_valid();
      logic [31:0] rd, wa;
      mem_read_data   = '1;
      mem_read_valid  = 1'b1;
      mem_write_valid = 1'b1;
      @(posedge CLK); #1;
      mem_read_valid  = 1'b0;
      mem_write_valid = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if (miss !== 1'b0 || mem_read_req !== 1'b0 || mem_write_req !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL stray_valid got=%b%b%b exp=000", miss, mem_read_req, mem_write_req);
      end
      @(posedge CLK); #1;
      access(1'b0, 32'h0000_3008, 2'd2, 32'd0, rd, wa);
   endtask

   task automatic test_random();
      logic [31:0] rd, wa, addr;
      for (int n = 0; n < 200; n++) begin
         addr = (32'($urandom_range(0, 3)) << 14) | (32'(9'h080 + $urandom_range(0, 1)) << 5)
                | 32'($urandom_range(0, 31));
         access(1'($urandom_range(0, 1)), addr, 2'($urandom_range(0, 3)), $urandom, rd, wa);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      RESET              = 1'b1;
      data_address_2C    = '0;
      data_write_2C      = '0;
      data_write_size_2C = '0;
      cache_read         = 1'b0;
      cache_write        = 1'b0;
      mem_write_valid    = 1'b0;
      mem_read_valid     = 1'b0;
      mem_read_data      = '0;
      test_reset();
      test_cold_read();
      test_byte_store();
      test_evict_dirty();
      test_lru_victim();
      test_reset_in_fill();
      test_stray_valid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
